counter_sequencer: RTL and testbench

- Command front-end that sits directly upstream of the 8-bit up/down counter (MC10E136-style, mode 00=preset, 01=down, 10=up, 11=hold).
- Accepts load / count-up-N / count-down-N commands over a valid/ready handshake and drives the counter's `mode` and `preset` inputs cycle by cycle.
- Keeps a shadow copy of the counter value, flags wrap-around, and pulses `done` when the command completes.
- Shares `clk` and `reset` with the counter, so the shadow and the counter stay in lockstep without reading back the counter output.

---
 rtl/counter_sequencer.sv | 146 ++++++++++++++
 tb/tb_counter_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Command front-end for an 8-bit up/down counter (preset/down/up/hold modes).
// Drives the counter's mode/preset cycle by cycle and keeps a lockstep shadow
// of the counter value, flagging wrap-around and pulsing done on completion.
module counter_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] preset,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             wrapped,
   output logic [WIDTH-1:0] shadow
);

   localparam logic [1:0] OP_LOAD     = 2'b00;
   localparam logic [1:0] OP_DOWN     = 2'b01;
   localparam logic [1:0] OP_UP       = 2'b10;
   localparam logic [1:0] MODE_PRESET = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_UP     = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] preset_q, preset_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             wrapped_q, wrapped_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   // Next-state and output decode; shadow tracks what the counter does at each edge.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      preset_d    = preset_q;
      shadow_d    = shadow_q;
      remaining_d = remaining_q;
      wrapped_d   = wrapped_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               wrapped_d = 1'b0;
               if (cmd_op == OP_LOAD) begin
                  preset_d = cmd_data;
                  mode_d   = MODE_PRESET;
                  state_d  = ST_LOAD;
               end else if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_data != '0) begin
                  mode_d      = (cmd_op == OP_UP) ? MODE_UP : MODE_DOWN;
                  remaining_d = cmd_data;
                  state_d     = ST_RUN;
               end else begin
                  // Zero-length count or nop: complete without touching the counter.
                  done_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            shadow_d = preset_q;
            mode_d   = MODE_HOLD;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_RUN: begin
            if (mode_q == MODE_UP) begin
               shadow_d = shadow_q + WIDTH'(1);
               if (shadow_q == '1) wrapped_d = 1'b1;
            end else begin
               shadow_d = shadow_q - WIDTH'(1);
               if (shadow_q == '0) wrapped_d = 1'b1;
            end
            remaining_d = remaining_q - WIDTH'(1);
            // This edge has already stepped the counter, so abort only stops further steps.
            if (abort || remaining_q == WIDTH'(1)) begin
               mode_d    = MODE_HOLD;
               done_d    = 1'b1;
               aborted_d = abort;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            mode_d  = MODE_HOLD;
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = ~ready_d;
   end

   // State and output registers, shared asynchronous reset with the counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_HOLD;
         preset_q    <= '0;
         shadow_q    <= '0;
         remaining_q <= '0;
         wrapped_q   <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         preset_q    <= preset_d;
         shadow_q    <= shadow_d;
         remaining_q <= remaining_d;
         wrapped_q   <= wrapped_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign mode      = mode_q;
   assign preset    = preset_q;
   assign shadow    = shadow_q;
   assign wrapped   = wrapped_q;
   assign done      = done_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus randomized commands,
// checked every cycle against a trace model that expands each accepted
// command into its full sequence of expected output frames.
module tb_counter_sequencer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b11;
   logic [W-1:0] cmd_data = '0;
   logic         abort = 1'b0;
   logic [1:0]   mode;
   logic [W-1:0] preset;
   logic         busy, done, aborted, wrapped;
   logic [W-1:0] shadow;

   counter_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .mode(mode),
      .preset(preset), .busy(busy), .done(done), .aborted(aborted),
      .wrapped(wrapped), .shadow(shadow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] preset;
      logic [7:0] shadow;
      logic       done;
      logic       aborted;
      logic       wrapped;
      logic       ready;
   } frame_t;

   frame_t exp_f;
   frame_t fq[$];
   int     plan_abort = 0;
   bit     acc_flag = 1'b0;
   bit     cmp_en = 1'b0;
   int     checks = 0;
   int     failures = 0;
   int     dcyc = 0, dut_last_acc = 0, dut_prev_acc = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
      end
   endtask

   function automatic frame_t reset_frame();
      frame_t f;
      f.mode = 2'b11; f.preset = 8'h00; f.shadow = 8'h00;
      f.done = 1'b0; f.aborted = 1'b0; f.wrapped = 1'b0; f.ready = 1'b1;
      return f;
   endfunction

   // Expand an accepted command into the frames seen after each following edge.
   task automatic gen_cmd(input logic [1:0] op, input logic [7:0] d, input int j);
      frame_t f;
      int s, n, len, v;
      bit up, ab;
      s = int'(exp_f.shadow);
      f = exp_f;
      f.wrapped = 1'b0; f.done = 1'b0; f.aborted = 1'b0;
      fq.delete();
      if (op == 2'b00) begin
         f.mode = 2'b00; f.preset = d; f.ready = 1'b0;
         fq.push_back(f);
         f.mode = 2'b11; f.shadow = d; f.done = 1'b1; f.ready = 1'b1;
         fq.push_back(f);
      end else if (op == 2'b11 || d == 8'h00) begin
         f.mode = 2'b11; f.done = 1'b1; f.ready = 1'b1;
         fq.push_back(f);
      end else begin
         n   = int'(d);
         up  = (op == 2'b10);
         ab  = (j >= 1 && j <= n);
         len = ab ? j : n;
         f.mode = op; f.ready = 1'b0;
         fq.push_back(f);
         for (int i = 1; i <= len; i++) begin
            v = up ? s + i : s - i;
            f.shadow  = 8'(v);
            f.wrapped = up ? (v > 255) : (v < 0);
            if (i == len) begin
               f.mode = 2'b11; f.done = 1'b1; f.aborted = ab; f.ready = 1'b1;
            end
            fq.push_back(f);
         end
      end
      exp_f = fq.pop_front();
   endtask

   // Reference model: advance one frame per edge, start a new trace on acceptance.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         fq.delete();
         exp_f    = reset_frame();
         acc_flag = 1'b0;
      end else begin
         acc_flag = cmd_valid && exp_f.ready;
         if (acc_flag) gen_cmd(cmd_op, cmd_data, plan_abort);
         else if (fq.size() > 0) exp_f = fq.pop_front();
         else begin
            exp_f.mode = 2'b11; exp_f.done = 1'b0; exp_f.aborted = 1'b0; exp_f.ready = 1'b1;
         end
      end
   end

   // Acceptance edges as seen on the DUT handshake.
   always @(posedge clk) begin
      dcyc++;
      if (!reset && cmd_valid && cmd_ready) begin
         dut_prev_acc = dut_last_acc;
         dut_last_acc = dcyc;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mode",    8'(mode),      8'(exp_f.mode));
         chk("preset",  preset,        exp_f.preset);
         chk("shadow",  shadow,        exp_f.shadow);
         chk("done",    8'(done),      8'(exp_f.done));
         chk("aborted", 8'(aborted),   8'(exp_f.aborted));
         chk("wrapped", 8'(wrapped),   8'(exp_f.wrapped));
         chk("ready",   8'(cmd_ready), 8'(exp_f.ready));
         chk("busy",    8'(busy),      8'(!exp_f.ready));
      end
   end

   // Present a command, wait for acceptance, then optionally pulse abort on RUN edge j.
   task automatic issue(input logic [1:0] op, input logic [7:0] d, input int j, input bit keep);
      int n;
      n = 0;
      plan_abort = j; cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!acc_flag && n < 400);
      chk("accept_in_time", 8'(acc_flag), 8'd1);
      if (!keep || j > 0) cmd_valid = 1'b0;
      if (op != 2'b00) abort = 1'b0;
      if (j > 0) begin
         repeat (j - 1) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!exp_f.ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_time", 8'(n < 600), 8'd1);
   endtask

   initial begin
      logic [1:0] op;
      logic [7:0] d;
      int         j;
      bit         keep, prev_keep;

      #1 reset = 1'b1;
      cmp_en = 1'b1;
      #1;
      chk("rst_mode", 8'(mode), 8'd3);
      chk("rst_shadow", shadow, 8'h00);
      chk("rst_ready", 8'(cmd_ready), 8'd1);
      chk("rst_busy", 8'(busy), 8'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Load 0x5A.
      issue(2'b00, 8'h5A, 0, 1'b0);
      chk("load_mode_preset", 8'(mode), 8'd0);
      wait_done();
      chk("load_shadow", shadow, 8'h5A);
      chk("load_done", 8'(done), 8'd1);
      chk("load_wrapped", 8'(wrapped), 8'd0);

      // Up 3 from 0xFE wraps.
      issue(2'b00, 8'hFE, 0, 1'b0); wait_done();
      issue(2'b10, 8'd3, 0, 1'b0); wait_done();
      chk("up_shadow", shadow, 8'h01);
      chk("up_wrapped", 8'(wrapped), 8'd1);

      // Down 4 from 0x02 wraps; nop clears wrapped.
      issue(2'b00, 8'h02, 0, 1'b0); wait_done();
      issue(2'b01, 8'd4, 0, 1'b0); wait_done();
      chk("down_shadow", shadow, 8'hFE);
      chk("down_wrapped", 8'(wrapped), 8'd1);
      issue(2'b11, 8'h00, 0, 1'b0);
      chk("nop_done", 8'(done), 8'd1);
      chk("nop_wrapped", 8'(wrapped), 8'd0);

      // Abort on the 4th RUN edge of up 10 from 0x10.
      issue(2'b00, 8'h10, 0, 1'b0); wait_done();
      issue(2'b10, 8'd10, 4, 1'b0); wait_done();
      chk("abort_shadow", shadow, 8'h14);
      chk("abort_aborted", 8'(aborted), 8'd1);
      chk("abort_done", 8'(done), 8'd1);
      chk("abort_mode", 8'(mode), 8'd3);

      // Zero-length, then back-to-back with valid held.
      issue(2'b01, 8'd0, 0, 1'b0);
      chk("zero_done", 8'(done), 8'd1);
      chk("zero_mode", 8'(mode), 8'd3);
      chk("zero_shadow", shadow, 8'h14);
      issue(2'b10, 8'd2, 0, 1'b1);
      issue(2'b00, 8'h33, 0, 1'b0);
      chk("b2b_gap", 8'(dut_last_acc - dut_prev_acc), 8'd3);
      wait_done();

      // A valid pulse while busy is dropped.
      issue(2'b10, 8'd30, 0, 1'b0);
      repeat (3) @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done();
      chk("busy_pulse_shadow", shadow, 8'h51);

      // Reset after 7 steps of up 20 from 0x00.
      issue(2'b00, 8'h00, 0, 1'b0); wait_done();
      issue(2'b10, 8'd20, 0, 1'b0);
      repeat (7) @(negedge clk);
      chk("pre_reset_shadow", shadow, 8'h07);
      #1 reset = 1'b1;
      #1;
      chk("midrst_mode", 8'(mode), 8'd3);
      chk("midrst_shadow", shadow, 8'h00);
      chk("midrst_done", 8'(done), 8'd0);
      chk("midrst_ready", 8'(cmd_ready), 8'd1);
      chk("midrst_preset", preset, 8'h00);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      issue(2'b00, 8'hA5, 0, 1'b0); wait_done();
      chk("post_rst_load", shadow, 8'hA5);

      // Randomized commands.
      prev_keep = 1'b0;
      for (int k = 0; k < 150; k++) begin
         op = 2'($urandom_range(0, 3));
         if (op == 2'b00 || $urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 255));
         else d = 8'($urandom_range(0, 12));
         j = 0;
         if ((op == 2'b01 || op == 2'b10) && $urandom_range(0, 3) == 0)
            j = int'($urandom_range(1, int'(d) + 2));
         keep = (j == 0) && ($urandom_range(0, 2) == 0);
         if (!prev_keep) abort = 1'($urandom_range(0, 1));
         issue(op, d, j, keep);
         if (!keep) wait_done();
         prev_keep = keep;
      end
      cmd_valid = 1'b0;
      abort = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
